// File: rtl/ieeedrv_sdarb.sv
// ieeedrv_sdarb: round-robin arbiter that shares one SD block port among SUBDRV sub-drive channels.
// Define IEEEDRV_SDARB_TIMEOUT_EN to add a TOW-bit watchdog to the REQ and XFER states.
module ieeedrv_sdarb #(
  parameter int SUBDRV = 2,
  parameter int BLKW   = 6,
  parameter int TOW    = 24
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [SUBDRV-1:0]      ch_rd,
  input  logic [SUBDRV-1:0]      ch_wr,
  input  logic [32*SUBDRV-1:0]   ch_lba,
  input  logic [BLKW*SUBDRV-1:0] ch_blk_cnt,
  output logic [SUBDRV-1:0]      ch_busy,
  output logic [SUBDRV-1:0]      ch_done,
  output logic [SUBDRV-1:0]      ch_err,
  output logic [SUBDRV-1:0]      ch_buff_wr,
  input  logic [8*SUBDRV-1:0]    ch_buff_din,
  output logic [31:0]            sd_lba,
  output logic [BLKW-1:0]        sd_blk_cnt,
  output logic                   sd_rd,
  output logic                   sd_wr,
  input  logic                   sd_ack,
  input  logic                   sd_buff_wr,
  output logic [7:0]             sd_buff_din
);
  localparam int PW = (SUBDRV > 1) ? $clog2(SUBDRV) : 1;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     grant_q, grant_d, ptr_q, ptr_d, grant_nxt;
  logic [31:0]       lba_q, lba_d;
  logic [BLKW-1:0]   blk_q, blk_d;
  logic              wr_dir_q, wr_dir_d;
  logic              sd_rd_q, sd_rd_d, sd_wr_q, sd_wr_d;
  logic [SUBDRV-1:0] busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [SUBDRV-1:0] wr_served_q, wr_served_d;
  logic [SUBDRV-1:0] pend_wr, req_any;
  logic [PW-1:0]     sel, sel_hi, sel_lo;
  logic              found, found_hi, found_lo;
  logic              gnt_held, wd_expired;

  // A write already served while the channel still holds ch_rd lets the read win the next grant.
  assign pend_wr   = ch_wr & ~wr_served_q;
  assign req_any   = ch_rd | pend_wr;
  assign gnt_held  = wr_dir_q ? ch_wr[grant_q] : ch_rd[grant_q];
  assign grant_nxt = (int'(grant_q) == SUBDRV - 1) ? '0 : grant_q + 1'b1;

`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  logic [TOW-1:0] wd_q, wd_d;
  assign wd_expired = &wd_q;
`else
  assign wd_expired = 1'b0;
`endif

  // Round-robin: lowest requester at or above the pointer, else lowest below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = SUBDRV - 1; i >= 0; i--) begin
      if (req_any[i] && (i >= int'(ptr_q))) begin
        found_hi = 1'b1;
        sel_hi   = PW'(i);
      end
      if (req_any[i] && (i < int'(ptr_q))) begin
        found_lo = 1'b1;
        sel_lo   = PW'(i);
      end
    end
    found = found_hi | found_lo;
    sel   = found_hi ? sel_hi : sel_lo;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    lba_d       = lba_q;
    blk_d       = blk_q;
    wr_dir_d    = wr_dir_q;
    sd_rd_d     = sd_rd_q;
    sd_wr_d     = sd_wr_q;
    busy_d      = busy_q;
    done_d      = '0;
    err_d       = '0;
    wr_served_d = wr_served_q & ch_wr;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d      = REQ;
          grant_d      = sel;
          lba_d        = ch_lba[int'(sel)*32 +: 32];
          blk_d        = ch_blk_cnt[int'(sel)*BLKW +: BLKW];
          wr_dir_d     = pend_wr[sel];
          sd_wr_d      = pend_wr[sel];
          sd_rd_d      = ~pend_wr[sel];
          busy_d       = '0;
          busy_d[sel]  = 1'b1;
        end
      end
      REQ: begin
        if (sd_ack) begin
          state_d = XFER;
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
        end else if (!gnt_held || wd_expired) begin
          // An abandoned request keeps the pointer; a watchdog expiry moves past the stuck channel.
          state_d        = IDLE;
          sd_rd_d        = 1'b0;
          sd_wr_d        = 1'b0;
          busy_d         = '0;
          err_d[grant_q] = 1'b1;
          if (gnt_held) ptr_d = grant_nxt;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_d              = DONE;
          done_d[grant_q]      = 1'b1;
          wr_served_d[grant_q] = wr_dir_q;
        end else if (wd_expired) begin
          state_d        = IDLE;
          busy_d         = '0;
          err_d[grant_q] = 1'b1;
          ptr_d          = grant_nxt;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = '0;
        ptr_d   = grant_nxt;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      lba_q       <= '0;
      blk_q       <= '0;
      wr_dir_q    <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      busy_q      <= '0;
      done_q      <= '0;
      err_q       <= '0;
      wr_served_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      lba_q       <= lba_d;
      blk_q       <= blk_d;
      wr_dir_q    <= wr_dir_d;
      sd_rd_q     <= sd_rd_d;
      sd_wr_q     <= sd_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      wr_served_q <= wr_served_d;
    end
  end

`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  // Counter restarts on every state change, so REQ and XFER each get a full window.
  assign wd_d = ((state_d == state_q) && ((state_q == REQ) || (state_q == XFER))) ?
                wd_q + 1'b1 : '0;

  always_ff @(posedge clk_sys) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`endif

  assign ch_busy     = busy_q;
  assign ch_done     = done_q;
  assign ch_err      = err_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = lba_q;
  assign sd_blk_cnt  = blk_q;
  assign ch_buff_wr  = busy_q & {SUBDRV{sd_buff_wr & sd_ack}};
  assign sd_buff_din = (|busy_q) ? ch_buff_din[int'(grant_q)*8 +: 8] : 8'h00;

endmodule

// File: tb/tb_ieeedrv_sdarb.sv
// tb_ieeedrv_sdarb: vector table plus grant scoreboard for the two-channel SD arbiter.
// Build with IEEEDRV_SDARB_TIMEOUT_EN defined to also exercise the watchdog with TOW=4.
module tb_ieeedrv_sdarb;
  localparam int SUBDRV = 2;
  localparam int BLKW   = 6;
`ifdef IEEEDRV_SDARB_TIMEOUT_EN
  localparam int TOW = 4;
`else
  localparam int TOW = 24;
`endif

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic [1:0]        ch_rd   = '0;
  logic [1:0]        ch_wr   = '0;
  logic [31:0]       lba_r [2];
  logic [BLKW-1:0]   blk_r [2];
  logic [63:0]       ch_lba;
  logic [11:0]       ch_blk_cnt;
  logic [15:0]       ch_buff_din;
  logic [1:0]        ch_busy, ch_done, ch_err, ch_buff_wr;
  logic [31:0]       sd_lba;
  logic [BLKW-1:0]   sd_blk_cnt;
  logic              sd_rd, sd_wr;
  logic              sd_ack     = 1'b0;
  logic              sd_buff_wr = 1'b0;
  logic [7:0]        sd_buff_din;

  assign ch_lba      = {lba_r[1], lba_r[0]};
  assign ch_blk_cnt  = {blk_r[1], blk_r[0]};
  assign ch_buff_din = {8'h3C, 8'hA5};

  always #5 clk_sys = ~clk_sys;

  ieeedrv_sdarb #(.SUBDRV(SUBDRV), .BLKW(BLKW), .TOW(TOW)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .ch_rd       (ch_rd),
    .ch_wr       (ch_wr),
    .ch_lba      (ch_lba),
    .ch_blk_cnt  (ch_blk_cnt),
    .ch_busy     (ch_busy),
    .ch_done     (ch_done),
    .ch_err      (ch_err),
    .ch_buff_wr  (ch_buff_wr),
    .ch_buff_din (ch_buff_din),
    .sd_lba      (sd_lba),
    .sd_blk_cnt  (sd_blk_cnt),
    .sd_rd       (sd_rd),
    .sd_wr       (sd_wr),
    .sd_ack      (sd_ack),
    .sd_buff_wr  (sd_buff_wr),
    .sd_buff_din (sd_buff_din)
  );

  typedef struct {
    logic            ch;
    logic            wr;
    logic [31:0]     lba;
    logic [BLKW-1:0] blk;
  } exp_t;

  typedef struct {
    logic [1:0]      rd;
    logic [1:0]      wr;
    logic [31:0]     lba0;
    logic [31:0]     lba1;
    logic [BLKW-1:0] blk0;
    logic [BLKW-1:0] blk1;
    int              n;
    logic [3:0]      ech;  // bit k: channel of the k-th grant
    logic [3:0]      ewr;  // bit k: k-th grant is a write
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {8'h00, ch_busy, ch_done, ch_err, ch_buff_wr, sd_rd, sd_wr,
            sd_lba, sd_blk_cnt, sd_buff_din};
  endfunction

  // Requests set by the caller are already visible while reset is high.
  task automatic do_reset();
    reset      = 1'b1;
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("reset_outs", outs(), 64'h0);
    reset = 1'b0;
  endtask

  task automatic push_exp(input logic ch, input logic wr, input logic [31:0] lba,
                          input logic [BLKW-1:0] blk);
    exp_t e;
    e.ch = ch; e.wr = wr; e.lba = lba; e.blk = blk;
    sb_q.push_back(e);
  endtask

  // Act as the SD device for one grant and compare it to the next scoreboard entry.
  task automatic serve(input int ack_len, input int exp_wait);
    exp_t       e;
    int         waited;
    logic [1:0] oh;
    logic [7:0] din;
    if (sb_q.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL sb_empty: got 0 entries expected at least 1");
      return;
    end
    e      = sb_q.pop_front();
    oh     = e.ch ? 2'b10 : 2'b01;
    din    = e.ch ? 8'h3C : 8'hA5;
    waited = 0;
    while (!(sd_rd || sd_wr) && waited < 20) begin
      waited++;
      @(negedge clk_sys);
    end
    check("grant_latency", 64'(waited), 64'(exp_wait));
    if (!(sd_rd || sd_wr)) return;
    check("grant", {ch_busy, sd_rd, sd_wr, sd_lba, sd_blk_cnt}, {oh, ~e.wr, e.wr, e.lba, e.blk});
    lba_r[e.ch] = ~e.lba;
    blk_r[e.ch] = ~e.blk;
    sd_ack      = 1'b1;
    sd_buff_wr  = 1'b1;
    for (int k = 0; k < ack_len; k++) begin
      @(negedge clk_sys);
      if (k == 0)
        check("xfer", {sd_rd, sd_wr, ch_buff_wr, sd_buff_din, sd_lba, sd_blk_cnt},
                      {2'b00, oh, din, e.lba, e.blk});
    end
    sd_ack     = 1'b0;
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    check("done", {ch_done, ch_err, ch_busy, sd_lba}, {oh, 2'b00, oh, e.lba});
    lba_r[e.ch] = e.lba;
    blk_r[e.ch] = e.blk;
    if (!(e.wr && ch_rd[e.ch])) begin
      ch_rd[e.ch] = 1'b0;
      ch_wr[e.ch] = 1'b0;
    end
    @(negedge clk_sys);
    check("done_pulse", {ch_done, ch_err, ch_busy, sd_rd, sd_wr}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{rd:2'b01, wr:2'b00, lba0:32'h0000_1000, lba1:32'hFFFF_FFFF, blk0:6'h01, blk1:6'h02, n:1, ech:4'b0000, ewr:4'b0000};
    vecs[1] = '{rd:2'b10, wr:2'b00, lba0:32'h0000_0000, lba1:32'hDEAD_BEEF, blk0:6'h00, blk1:6'h3F, n:1, ech:4'b0001, ewr:4'b0000};
    vecs[2] = '{rd:2'b11, wr:2'b00, lba0:32'h0000_0010, lba1:32'h0000_0020, blk0:6'h04, blk1:6'h08, n:2, ech:4'b0010, ewr:4'b0000};
    vecs[3] = '{rd:2'b00, wr:2'b11, lba0:32'h8000_0000, lba1:32'h7FFF_FFFF, blk0:6'h3F, blk1:6'h00, n:2, ech:4'b0010, ewr:4'b0011};
    vecs[4] = '{rd:2'b01, wr:2'b01, lba0:32'h0000_0165, lba1:32'h0000_0999, blk0:6'h05, blk1:6'h06, n:2, ech:4'b0000, ewr:4'b0001};
    vecs[5] = '{rd:2'b10, wr:2'b01, lba0:32'h1234_5678, lba1:32'h9ABC_DEF0, blk0:6'h11, blk1:6'h22, n:2, ech:4'b0010, ewr:4'b0001};
    vecs[6] = '{rd:2'b11, wr:2'b11, lba0:32'h0000_0AAA, lba1:32'h0000_0BBB, blk0:6'h0A, blk1:6'h0B, n:4, ech:4'b1010, ewr:4'b0011};
    vecs[7] = '{rd:2'b00, wr:2'b10, lba0:32'h0000_0001, lba1:32'h0000_0002, blk0:6'h03, blk1:6'h15, n:1, ech:4'b0001, ewr:4'b0001};

    for (int i = 0; i < 8; i++) begin
      ch_rd    = vecs[i].rd;
      ch_wr    = vecs[i].wr;
      lba_r[0] = vecs[i].lba0;
      lba_r[1] = vecs[i].lba1;
      blk_r[0] = vecs[i].blk0;
      blk_r[1] = vecs[i].blk1;
      for (int k = 0; k < vecs[i].n; k++)
        push_exp(vecs[i].ech[k], vecs[i].ewr[k],
                 vecs[i].ech[k] ? vecs[i].lba1 : vecs[i].lba0,
                 vecs[i].ech[k] ? vecs[i].blk1 : vecs[i].blk0);
      do_reset();
      for (int k = 0; k < vecs[i].n; k++) serve(1 + k, 1);
    end

    // Channel 1 drops its read while still waiting for sd_ack.
    ch_rd = 2'b10; ch_wr = 2'b00;
    do_reset();
    @(negedge clk_sys);
    check("abort_req", {ch_busy, sd_rd, sd_wr}, {2'b10, 1'b1, 1'b0});
    ch_rd = 2'b00;
    @(negedge clk_sys);
    check("abort_err", {ch_err, ch_done, ch_busy, sd_rd, sd_wr}, {2'b10, 2'b00, 2'b00, 2'b00});
    @(negedge clk_sys);
    check("abort_err_pulse", {ch_err, ch_done}, 64'h0);

    // sd_ack in IDLE has no effect.
    do_reset();
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_sys);
      check("idle_ack_ignored", outs(), 64'h0);
    end
    sd_ack = 1'b0; sd_buff_wr = 1'b0;

    // Move the pointer to 1, then reset in the middle of a channel-1 transfer.
    lba_r[0] = 32'h0000_0C00; blk_r[0] = 6'h07;
    lba_r[1] = 32'h0000_0D00; blk_r[1] = 6'h09;
    ch_rd = 2'b01;
    push_exp(1'b0, 1'b0, 32'h0000_0C00, 6'h07);
    do_reset();
    serve(2, 1);
    ch_rd = 2'b10;
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("pre_reset_grant", {ch_busy, sd_rd}, {2'b10, 1'b1});
    sd_ack = 1'b1; sd_buff_wr = 1'b1;
    @(negedge clk_sys);
    check("xfer_buff_wr", {ch_buff_wr, sd_buff_din}, {2'b10, 8'h3C});
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    sd_buff_wr = 1'b1;
    reset      = 1'b1;
    @(negedge clk_sys);
    check("reset_mid_xfer", outs(), 64'h0);
    sd_buff_wr = 1'b0;
    @(negedge clk_sys);
    check("reset_no_pulse", {ch_done, ch_err, ch_buff_wr}, 64'h0);
    sd_ack = 1'b0;
    ch_rd  = 2'b11;
    reset  = 1'b0;
    @(negedge clk_sys);
    check("reset_ptr_zero", {ch_busy, sd_rd, sd_lba}, {2'b01, 1'b1, 32'h0000_0C00});

    // Channel 1 keeps requesting while channel 0 asks once: grants must alternate.
    ch_rd = 2'b10; ch_wr = 2'b00;
    push_exp(1'b1, 1'b0, 32'h0000_0D00, 6'h09);
    push_exp(1'b0, 1'b0, 32'h0000_0C00, 6'h07);
    push_exp(1'b1, 1'b0, 32'h0000_0D00, 6'h09);
    do_reset();
    @(negedge clk_sys);
    ch_rd[0] = 1'b1;
    serve(3, 0);
    ch_rd[1] = 1'b1;
    serve(3, 1);
    serve(3, 1);

`ifdef IEEEDRV_SDARB_TIMEOUT_EN
    // sd_ack never rises: 16 REQ cycles, then ch_err and the other channel is granted.
    begin
      int cnt;
      ch_rd = 2'b11; ch_wr = 2'b00;
      do_reset();
      @(negedge clk_sys);
      cnt = 0;
      while (ch_err == 2'b00 && cnt < 40) begin
        cnt++;
        @(negedge clk_sys);
      end
      check("wd_cycles", 64'(cnt), 64'd16);
      check("wd_err", {ch_err, ch_busy, sd_rd, ch_done}, {2'b01, 2'b00, 1'b0, 2'b00});
      @(negedge clk_sys);
      check("wd_next_grant", {ch_busy, sd_rd, ch_err}, {2'b10, 1'b1, 2'b00});
      ch_rd = 2'b00;
      do_reset();
    end
`endif

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
